// File: rtl/fmps_packet_rx.sv
// FMPS test link receiver: parses header + payload words from the
// Aurora RX stream and reports good packets, framing status and counts.
module fmps_packet_rx #(
  parameter int MAGIC_WIDTH     = 16,
  parameter int MAGIC_START_BIT = 16,
  parameter int INDEX_WIDTH     = 5,
  parameter int INDEX_START_BIT = 10,
  parameter int NUM_DATA_WORDS  = 1,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                         auroraUserClk,
  input  logic                         auroraResetN,
  input  logic                         auroraChannelUp,
  input  logic                         auroraFAstrobe,
  input  logic [MAGIC_WIDTH-1:0]       expectedHeaderMagic,
  input  logic [31:0]                  AXIS_RX_tdata,
  input  logic                         AXIS_RX_tvalid,
  input  logic                         AXIS_RX_tlast,
  output logic                         AXIS_RX_tready,
  output logic                         packetStrobe,
  output logic [INDEX_WIDTH-1:0]       packetIndex,
  output logic [32*NUM_DATA_WORDS-1:0] packetData,
  output logic                         statusStrobe,
  output logic [1:0]                   statusCode,
  output logic [COUNT_WIDTH-1:0]       cyclePacketCount
);

  localparam int DW = 32 * NUM_DATA_WORDS;
  localparam int CW = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(NUM_DATA_WORDS - 1);

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_MAGIC = 2'd1;
  localparam logic [1:0] ST_SHORT = 2'd2;
  localparam logic [1:0] ST_LONG  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   bad_q, bad_d;
  logic [INDEX_WIDTH-1:0] stIdx_q, stIdx_d;
  logic [DW-1:0]          stData_q, stData_d;
  logic                   ready_q;
  logic                   pktStb_q, pktStb_d;
  logic                   stsStb_q, stsStb_d;
  logic [1:0]             code_q, code_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [DW-1:0]          data_q, data_d;
  logic [COUNT_WIDTH-1:0] run_q, run_d;
  logic [COUNT_WIDTH-1:0] cyc_q, cyc_d;

  logic                   beat;
  logic                   hdrOk;
  logic [DW-1:0]          merged;
  logic [COUNT_WIDTH-1:0] runInc;

  assign beat  = AXIS_RX_tvalid & ready_q;
  assign hdrOk = AXIS_RX_tdata[MAGIC_START_BIT +: MAGIC_WIDTH]
                 == expectedHeaderMagic;

  // Staged payload with the current beat dropped into its word slot.
  always_comb begin
    merged = stData_q;
    for (int w = 0; w < NUM_DATA_WORDS; w++) begin
      if (cnt_q == CW'(w)) merged[w*32 +: 32] = AXIS_RX_tdata;
    end
  end

  // Framing FSM; a bad-magic packet reports its status on its tlast beat.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    stIdx_d  = stIdx_q;
    stData_d = stData_q;
    pktStb_d = 1'b0;
    stsStb_d = 1'b0;
    code_d   = code_q;
    idx_d    = idx_q;
    data_d   = data_q;
    if (!auroraChannelUp) begin
      state_d = S_HDR;
      cnt_d   = '0;
      bad_d   = 1'b0;
    end else if (beat) begin
      unique case (1'b1)
        (state_q == S_HDR): begin
          stIdx_d = AXIS_RX_tdata[INDEX_START_BIT +: INDEX_WIDTH];
          cnt_d   = '0;
          unique case ({hdrOk, AXIS_RX_tlast})
            2'b01: begin
              stsStb_d = 1'b1;
              code_d   = ST_MAGIC;
            end
            2'b00: begin
              state_d = S_DISC;
              bad_d   = 1'b1;
            end
            2'b11: begin
              stsStb_d = 1'b1;
              code_d   = ST_SHORT;
            end
            default: state_d = S_DATA;
          endcase
        end
        (state_q == S_DATA): begin
          stData_d = merged;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST_WORD) begin
            stsStb_d = 1'b1;
            if (AXIS_RX_tlast) begin
              code_d   = ST_OK;
              pktStb_d = 1'b1;
              idx_d    = stIdx_q;
              data_d   = merged;
              state_d  = S_HDR;
            end else begin
              code_d  = ST_LONG;
              state_d = S_DISC;
              bad_d   = 1'b0;
            end
          end else if (AXIS_RX_tlast) begin
            stsStb_d = 1'b1;
            code_d   = ST_SHORT;
            state_d  = S_HDR;
          end
        end
        (state_q == S_DISC): begin
          if (AXIS_RX_tlast) begin
            state_d = S_HDR;
            bad_d   = 1'b0;
            if (bad_q) begin
              stsStb_d = 1'b1;
              code_d   = ST_MAGIC;
            end
          end
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  // Good-packet counter; a strobe landing on the FA edge closes that cycle.
  always_comb begin
    runInc = (run_q == '1) ? run_q : run_q + COUNT_WIDTH'(1);
    run_d  = run_q;
    cyc_d  = cyc_q;
    if (auroraFAstrobe) begin
      cyc_d = pktStb_q ? runInc : run_q;
      run_d = '0;
    end else if (pktStb_q) begin
      run_d = runInc;
    end
  end

  // State and output registers.
  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      state_q  <= S_HDR;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      stIdx_q  <= '0;
      stData_q <= '0;
      ready_q  <= 1'b0;
      pktStb_q <= 1'b0;
      stsStb_q <= 1'b0;
      code_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      run_q    <= '0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      stIdx_q  <= stIdx_d;
      stData_q <= stData_d;
      ready_q  <= auroraChannelUp;
      pktStb_q <= pktStb_d;
      stsStb_q <= stsStb_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      run_q    <= run_d;
      cyc_q    <= cyc_d;
    end
  end

  assign AXIS_RX_tready   = ready_q;
  assign packetStrobe     = pktStb_q;
  assign packetIndex      = idx_q;
  assign packetData       = data_q;
  assign statusStrobe     = stsStb_q;
  assign statusCode       = code_q;
  assign cyclePacketCount = cyc_q;

endmodule

// File: tb/tb_fmps_packet_rx.sv
// Scoreboard bench for fmps_packet_rx: packet-level reference model,
// randomized framing and handshake, FA-cycle count checks.
module tb_fmps_packet_rx;

  localparam int N = 2;
  localparam logic [15:0] MAGIC = 16'hB6CF;

  typedef struct packed {
    logic [1:0]  code;
    logic [4:0]  idx;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up;
  logic        fa;
  logic [15:0] magic_in;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic        pstb;
  logic [4:0]  pidx;
  logic [63:0] pdata;
  logic        sstb;
  logic [1:0]  scode;
  logic [7:0]  cnt;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t        sb[$];
  logic [7:0]  fa_q[$];
  logic [31:0] pkt[$];
  logic        cur_good = 1'b0;
  logic        rand_valid = 1'b0;
  int          run = 0;
  logic [4:0]  last_idx = '0;
  logic [63:0] last_data = '0;

  fmps_packet_rx #(
    .MAGIC_WIDTH(16), .MAGIC_START_BIT(16),
    .INDEX_WIDTH(5), .INDEX_START_BIT(10),
    .NUM_DATA_WORDS(N), .COUNT_WIDTH(8)
  ) dut (
    .auroraUserClk(clk),
    .auroraResetN(rst_n),
    .auroraChannelUp(up),
    .auroraFAstrobe(fa),
    .expectedHeaderMagic(magic_in),
    .AXIS_RX_tdata(tdata),
    .AXIS_RX_tvalid(tvalid),
    .AXIS_RX_tlast(tlast),
    .AXIS_RX_tready(tready),
    .packetStrobe(pstb),
    .packetIndex(pidx),
    .packetData(pdata),
    .statusStrobe(sstb),
    .statusCode(scode),
    .cyclePacketCount(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packet-level rules: magic, then payload length against N.
  function automatic exp_t model_pkt();
    exp_t e;
    logic [31:0] h;
    int nd;
    h = pkt[0];
    nd = pkt.size() - 1;
    e.idx = h[14:10];
    e.data = '0;
    if (h[31:16] != MAGIC) e.code = 2'd1;
    else if (nd < N) e.code = 2'd2;
    else if (nd > N) e.code = 2'd3;
    else begin
      e.code = 2'd0;
      e.data = {pkt[2], pkt[1]};
    end
    return e;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic l);
    logic acc;
    int guard;
    guard = 0;
    tdata = d;
    tlast = l;
    do begin
      tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = tvalid && tready;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 400) begin
        $display("FAIL beat_timeout: got tready=%b expected 1", tready);
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $fatal(1, "stream stalled");
      end
    end while (!acc);
    tvalid = 1'b0;
  endtask

  task automatic send_pkt();
    exp_t e;
    e = model_pkt();
    sb.push_back(e);
    cur_good = (e.code == 2'd0);
    for (int i = 0; i < pkt.size(); i++)
      send_beat(pkt[i], i == pkt.size() - 1);
  endtask

  task automatic fa_pulse();
    fa = 1'b1;
    @(posedge clk);
    #1 fa = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_tready", 64'(tready), 0);
    chk("rst_pstb", 64'(pstb), 0);
    chk("rst_sstb", 64'(sstb), 0);
    chk("rst_scode", 64'(scode), 0);
    chk("rst_pidx", 64'(pidx), 0);
    chk("rst_pdata", pdata, 0);
    chk("rst_count", 64'(cnt), 0);
  endtask

  // Monitor: one status per packet, in order; data only on good ones.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sstb) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL status_unexpected: got code %0d expected none",
                   scode);
        end else begin
          e = sb.pop_front();
          chk("status_code", 64'(scode), 64'(e.code));
          if (e.code == 2'd0) begin
            chk("pkt_strobe", 64'(pstb), 1);
            chk("pkt_index", 64'(pidx), 64'(e.idx));
            chk("pkt_data", pdata, e.data);
            last_idx = e.idx;
            last_data = e.data;
          end else begin
            chk("err_no_strobe", 64'(pstb), 0);
            chk("err_idx_hold", 64'(pidx), 64'(last_idx));
            chk("err_data_hold", pdata, last_data);
          end
        end
      end else if (pstb) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pkt_without_status: got strobe 1 expected 0");
      end
    end
  end

  // FA model: count good terminating beats between FA samples.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      fa_q.delete();
    end else begin
      if (fa_q.size() > 0)
        chk("fa_count", 64'(cnt), 64'(fa_q.pop_front()));
      if (fa) begin
        fa_q.push_back(run > 255 ? 8'hFF : 8'(run));
        run = 0;
      end
      if (tvalid && tready && tlast && cur_good) run++;
    end
  end

  initial begin
    int t;
    int len;
    logic [15:0] m;
    logic [31:0] h;
    rst_n = 1'b0;
    up = 1'b0;
    fa = 1'b0;
    magic_in = MAGIC;
    tdata = '0;
    tvalid = 1'b0;
    tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1 up = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    pkt = '{32'hB6CF0400, 32'h12345678, 32'h9ABCDEF0};
    send_pkt();
    pkt = '{32'hDEAD0400, 32'h11111111};
    send_pkt();
    pkt = '{32'hDEAD0800};
    send_pkt();
    pkt = '{32'hB6CF0800, 32'h22222222};
    send_pkt();
    pkt = '{32'hB6CF0C00};
    send_pkt();
    pkt = '{32'hB6CF1000, 32'hA, 32'hB, 32'hC};
    send_pkt();
    pkt = '{32'hB6CF1400, 32'hCAFEF00D, 32'h0BADBEEF};
    send_pkt();

    cur_good = 1'b0;
    send_beat(32'hB6CF1800, 1'b0);
    up = 1'b0;
    repeat (4) @(posedge clk);
    #1 up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pkt = '{32'hB6CF1C00, 32'h5A5A5A5A, 32'hA5A5A5A5};
    send_pkt();

    fa_pulse();
    repeat (3) begin
      h = {MAGIC, 1'b0, 5'($urandom), 10'($urandom)};
      pkt = '{h, $urandom, $urandom};
      send_pkt();
    end
    fa_pulse();
    repeat (5) @(posedge clk);
    #1;
    fa_pulse();

    rand_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      h = {MAGIC, 1'($urandom), 5'(k % 32), 10'($urandom)};
      pkt = '{h, $urandom, $urandom};
      send_pkt();
    end

    for (int k = 0; k < 60; k++) begin
      t = $urandom_range(0, 4);
      m = MAGIC;
      len = N + 1;
      if (t == 2) begin
        m = 16'($urandom);
        if (m == MAGIC) m = ~MAGIC;
        len = $urandom_range(1, 4);
      end else if (t == 3) begin
        len = $urandom_range(1, N);
      end else if (t == 4) begin
        len = $urandom_range(N + 2, N + 3);
      end
      h = {m, 1'($urandom), 5'($urandom), 10'($urandom)};
      pkt.delete();
      pkt.push_back(h);
      for (int j = 1; j < len; j++) pkt.push_back($urandom);
      send_pkt();
    end
    rand_valid = 1'b0;

    cur_good = 1'b0;
    send_beat(32'hB6CF2000, 1'b0);
    send_beat(32'h77777777, 1'b0);
    rst_n = 1'b0;
    last_idx = '0;
    last_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1;
    pkt = '{32'hB6CF2400, 32'h31415926, 32'h27182818};
    send_pkt();
    fa_pulse();

    for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
